// File: rtl/shift_add_multiplier.sv
// ============================================================================
// shift_add_multiplier : iterative unsigned NxN->2N shift-and-add multiplier
// Optional macro MUL_EARLY_TERM_EN ends BUSY early once the multiplier is 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_add_multiplier #(
   parameter int N = 32
) (
   input  logic           clk_i,
   input  logic           rstn_i,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic [N-1:0]   a_i,
   input  logic [N-1:0]   b_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [2*N-1:0] prod_o
);

   localparam int               CNT_W    = $clog2(N) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [1:0]       next_state;
   logic [N-1:0]     mult_a;
   logic [2*N-1:0]   acc;
   logic [CNT_W-1:0] cnt;

   logic [N-1:0]     p_hi;
   logic [N-1:0]     p_lo;
   logic [N-1:0]     sum;
   logic             carry;
   logic [2*N-1:0]   acc_step;
   logic [2*N-1:0]   acc_busy;
   logic             finish;

   assign p_hi = acc[2*N-1:N];
   assign p_lo = acc[N-1:0];

   // Single N-bit adder shared across all iterations: P_hi + A, carry-in 0.
   assign {carry, sum} = {1'b0, p_hi} + {1'b0, mult_a};

   always_comb begin
      acc_step = acc[0] ? {carry, sum, p_lo[N-1:1]}
                        : {1'b0, p_hi, p_lo[N-1:1]};
   end

`ifdef MUL_EARLY_TERM_EN
   logic [N-1:0]     remaining;
   logic             early;
   logic [CNT_W-1:0] shamt;

   // Low N-cnt bits of P_lo still hold unconsumed multiplier bits.
   assign remaining = p_lo & ({N{1'b1}} >> cnt);
   assign early     = (remaining == '0);
   assign shamt     = CNT_W'(N) - cnt;

   always_comb begin
      acc_busy = early ? (acc >> shamt) : acc_step;
      finish   = early || (cnt == CNT_LAST);
   end
`else
   always_comb begin
      acc_busy = acc_step;
      finish   = (cnt == CNT_LAST);
   end
`endif

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= S_IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (in_valid_i)  next_state = S_BUSY;
         S_BUSY:  if (finish)      next_state = S_DONE;
         S_DONE:  if (out_ready_i) next_state = S_IDLE;
         default:                  next_state = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready_o  = (state == S_IDLE);
      out_valid_o = (state == S_DONE);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mult_a <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid_i) begin
                  mult_a <= a_i;
                  acc    <= {{N{1'b0}}, b_i};
                  cnt    <= '0;
               end
            end
            S_BUSY: begin
               acc <= acc_busy;
               cnt <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign prod_o = acc;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// ============================================================================
// tb_shift_add_multiplier : directed self-checking bench, N=32 and N=4 builds
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shift_add_multiplier;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [63:0] prod;

   logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic [7:0]  prod4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_add_multiplier #(.N(32)) dut32 (
      .clk_i(clk), .rstn_i(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a_i(a), .b_i(b),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .prod_o(prod)
   );

   shift_add_multiplier #(.N(4)) dut4 (
      .clk_i(clk), .rstn_i(rst_n),
      .in_valid_i(in_valid4), .in_ready_o(in_ready4),
      .a_i(a4), .b_i(b4),
      .out_valid_o(out_valid4), .out_ready_i(out_ready4),
      .prod_o(prod4)
   );

   task automatic check(input logic [71:0] obs, input logic [71:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected accept-to-valid latency for multiplier v in an n-bit build.
   function automatic int lat_of(input logic [31:0] v, input int n);
`ifdef MUL_EARLY_TERM_EN
      int m;
      if (v == 0) return 1;
      m = 0;
      for (int i = 0; i < n; i++) if (v[i]) m = i;
      return (m + 2 < n) ? m + 2 : n;
`else
      return n;
`endif
   endfunction

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic mul32(input logic [31:0] ta, input logic [31:0] tb,
                        input logic [63:0] exp, input string tag);
      int lat;
      check(72'(in_ready), 72'(1), {tag, " in_ready"});
      in_valid = 1'b1; a = ta; b = tb;
      @(posedge clk); #1;
      in_valid = 1'b0; a = '0; b = '0;
      wait_valid(lat);
      check(72'(lat), 72'(lat_of(tb, 32)), {tag, " latency"});
      check(72'(prod), 72'(exp), {tag, " product"});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check(72'({out_valid, in_ready}), 72'(2'b01), {tag, " handshake"});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [7:0] exp4;

      repeat (2) @(posedge clk);
      #1;
      check(72'({in_ready, out_valid, prod}), 72'({2'b10, 64'h0}), "reset32");
      check(72'({in_ready4, out_valid4, prod4}), 72'({2'b10, 8'h0}), "reset4");
      rst_n = 1'b1;
      @(posedge clk); #1;

      mul32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");
      mul32(32'h1234_5678, 32'h0,         64'h0,                   "b_zero");
      mul32(32'd3,         32'h10,        64'h30,                  "b_0x10");
      mul32(32'hDEAD_BEEF, 32'd2,         64'h1_BD5B_7DDE,         "x2");
      mul32(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "msb");

      // Asynchronous reset on the fifth BUSY cycle of a multiply.
      in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check(72'({out_valid, in_ready, prod}), 72'({2'b01, 64'h0}), "reset_mid_busy");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      mul32(32'd7, 32'd6, 64'd42, "after_reset");

      // Backpressure with operand toggling while DONE.
      in_valid = 1'b1; a = 32'h1234; b = 32'h10;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(lat);
      check(72'(lat), 72'(lat_of(32'h10, 32)), "bp latency");
      for (int i = 0; i < 10; i++) begin
         in_valid = ~in_valid; a = 32'(i + 100); b = 32'(i + 1);
         @(posedge clk); #1;
         check(72'({out_valid, in_ready, prod}), 72'({2'b10, 64'h12340}), "bp hold");
      end
      out_ready = 1'b1; in_valid = 1'b1; a = 32'd5; b = 32'd9;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check(72'({out_valid, in_ready}), 72'(2'b01), "bp no accept at handshake");
      @(posedge clk); #1;
      in_valid = 1'b0;
      check(72'(in_ready), 72'(0), "bp accepted next cycle");
      wait_valid(lat);
      check(72'(lat), 72'(lat_of(32'd9, 32)), "bp2 latency");
      check(72'(prod), 72'(64'd45), "bp2 product");
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // N=4 exhaustive, back-to-back with out_ready held high.
      out_ready4 = 1'b1;
      for (int i = 0; i < 256; i++) begin
         a4 = 4'(i >> 4); b4 = 4'(i);
         exp4 = 8'(a4) * 8'(b4);
         lat = lat_of(32'(b4), 4);
         check(72'(in_ready4), 72'(1), "n4 ready");
         in_valid4 = 1'b1;
         @(posedge clk); #1;
         in_valid4 = 1'b0;
         repeat (lat - 1) @(posedge clk);
         #1;
         check(72'(out_valid4), 72'(0), "n4 not early");
         @(posedge clk); #1;
         check(72'({out_valid4, prod4}), 72'({1'b1, exp4}), "n4 product");
         @(posedge clk); #1;
      end
      out_ready4 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
